// File: rtl/q100_exu_trap_ctrl_pkg.sv
// Shared types and constants for the EXU trap controller.
package q100_exu_trap_ctrl_pkg;

  localparam int LEN_CSR      = 32;
  localparam int LEN_CSR_ADDR = 12;

  // mcause value used for the external machine interrupt.
  localparam logic [LEN_CSR-1:0] IRQ_EXT_CAUSE = 32'h8000_000B;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SAVE_EPC   = 3'd1,
    SAVE_CAUSE = 3'd2,
    SAVE_TVAL  = 3'd3,
    READ_VEC   = 3'd4,
    MRET_RD    = 3'd5,
    REDIRECT   = 3'd6
  } trap_state_e;

  // Synchronous exceptions carry their 5-bit code in the low bits, interrupt bit clear.
  function automatic logic [LEN_CSR-1:0] exc_cause(input logic [4:0] code);
    return {27'b0, code};
  endfunction

endpackage

// File: rtl/q100_config.svh
// Machine-mode CSR addresses used by the trap controller.
`ifndef Q100_CONFIG_SVH
`define Q100_CONFIG_SVH
localparam logic [11:0] CSR_MSTATUS = 12'h300;
localparam logic [11:0] CSR_MTVEC   = 12'h305;
localparam logic [11:0] CSR_MEPC    = 12'h341;
localparam logic [11:0] CSR_MCAUSE  = 12'h342;
localparam logic [11:0] CSR_MTVAL   = 12'h343;
`endif

// File: rtl/q100_exu_irq_sync.sv
// Two-flop synchronizer for the asynchronous level interrupt input.
module q100_exu_irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  output logic irq_sync_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw level through two flops; cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= irq_i;
      sync_q <= meta_q;
    end
  end

  assign irq_sync_o = sync_q;

endmodule

// File: rtl/q100_exu_trap_ctrl.sv
// Trap entry / return sequencer: saves mepc/mcause/mtval, fetches the vector
// (or mepc on mret) and issues a single-cycle fetch redirect. When idle it
// forwards instruction CSR writes to the CSR file.
module q100_exu_trap_ctrl
  import q100_exu_trap_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    insn_csr_vld_i,
  input  logic [LEN_CSR_ADDR-1:0] insn_csr_addr_i,
  input  logic [LEN_CSR-1:0]      insn_csr_wdata_i,
  output logic                    insn_csr_rdy_o,
  input  logic                    exc_vld_i,
  input  logic [4:0]              exc_code_i,
  input  logic [31:0]             exc_pc_i,
  input  logic [31:0]             exc_tval_i,
  input  logic                    irq_i,
  input  logic [31:0]             int_pc_i,
  input  logic                    mret_i,
  output logic [LEN_CSR-1:0]      csr_o,
  output logic [LEN_CSR_ADDR-1:0] csr_addr_o,
  output logic                    csr_vld_o,
  input  logic [LEN_CSR-1:0]      csr_i,
  output logic                    redirect_vld_o,
  output logic [31:0]             redirect_pc_o,
  output logic                    trap_busy_o
);

  `include "q100_config.svh"

  trap_state_e        state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [LEN_CSR-1:0] cause_q, cause_d;
  logic [31:0]        tval_q, tval_d;
  logic [31:0]        target_q, target_d;
  logic               irq_en_q, irq_en_d;
  logic               irq_sync;

  q100_exu_irq_sync u_irq_sync (
    .clk        (clk),
    .rst        (rst),
    .irq_i      (irq_i),
    .irq_sync_o (irq_sync)
  );

  // State and captured trap context; reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      target_q <= '0;
      irq_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      target_q <= target_d;
      irq_en_q <= irq_en_d;
    end
  end

  // Event arbitration in IDLE, sequencing of the CSR saves/reads and output drive.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    cause_d        = cause_q;
    tval_d         = tval_q;
    target_d       = target_q;
    irq_en_d       = irq_en_q;
    csr_o          = '0;
    csr_addr_o     = insn_csr_addr_i;
    csr_vld_o      = 1'b0;
    insn_csr_rdy_o = 1'b0;
    redirect_vld_o = 1'b0;
    redirect_pc_o  = '0;
    trap_busy_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Nothing is accepted while reset is held, so every output stays quiet.
        if (rst) begin
          if (exc_vld_i) begin
            pc_d        = exc_pc_i;
            cause_d     = exc_cause(exc_code_i);
            tval_d      = exc_tval_i;
            irq_en_d    = 1'b0;
            trap_busy_o = 1'b1;
            state_d     = SAVE_EPC;
          end else if (irq_sync && irq_en_q) begin
            pc_d        = int_pc_i;
            cause_d     = IRQ_EXT_CAUSE;
            tval_d      = '0;
            irq_en_d    = 1'b0;
            trap_busy_o = 1'b1;
            state_d     = SAVE_EPC;
          end else if (mret_i) begin
            irq_en_d    = 1'b1;
            trap_busy_o = 1'b1;
            state_d     = MRET_RD;
          end else begin
            insn_csr_rdy_o = 1'b1;
            if (insn_csr_vld_i) begin
              csr_vld_o = 1'b1;
              csr_o     = insn_csr_wdata_i;
              if (insn_csr_addr_i == CSR_MSTATUS) begin
                irq_en_d = insn_csr_wdata_i[3];
              end
            end
          end
        end
      end
      SAVE_EPC: begin
        trap_busy_o = 1'b1;
        csr_vld_o   = 1'b1;
        csr_addr_o  = CSR_MEPC;
        csr_o       = pc_q;
        state_d     = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        trap_busy_o = 1'b1;
        csr_vld_o   = 1'b1;
        csr_addr_o  = CSR_MCAUSE;
        csr_o       = cause_q;
        state_d     = SAVE_TVAL;
      end
      SAVE_TVAL: begin
        trap_busy_o = 1'b1;
        csr_vld_o   = 1'b1;
        csr_addr_o  = CSR_MTVAL;
        csr_o       = tval_q;
        state_d     = READ_VEC;
      end
      READ_VEC: begin
        // Direct mode only: the mode bits of mtvec are dropped.
        trap_busy_o = 1'b1;
        csr_addr_o  = CSR_MTVEC;
        target_d    = {csr_i[31:2], 2'b00};
        state_d     = REDIRECT;
      end
      MRET_RD: begin
        trap_busy_o = 1'b1;
        csr_addr_o  = CSR_MEPC;
        target_d    = csr_i;
        state_d     = REDIRECT;
      end
      REDIRECT: begin
        trap_busy_o    = 1'b1;
        redirect_vld_o = 1'b1;
        redirect_pc_o  = target_q;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_q100_exu_trap_ctrl.sv
// Directed plus randomized bench for the trap controller, checked cycle by
// cycle against a transaction-level model of the expected CSR/redirect activity.
module tb_q100_exu_trap_ctrl;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  logic        clk = 1'b0;
  logic        rst;
  logic        insn_csr_vld_i;
  logic [11:0] insn_csr_addr_i;
  logic [31:0] insn_csr_wdata_i;
  logic        insn_csr_rdy_o;
  logic        exc_vld_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic [31:0] exc_tval_i;
  logic        irq_i;
  logic [31:0] int_pc_i;
  logic        mret_i;
  logic [31:0] csr_o;
  logic [11:0] csr_addr_o;
  logic        csr_vld_o;
  logic [31:0] csr_i;
  logic        redirect_vld_o;
  logic [31:0] redirect_pc_o;
  logic        trap_busy_o;

  q100_exu_trap_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .insn_csr_vld_i   (insn_csr_vld_i),
    .insn_csr_addr_i  (insn_csr_addr_i),
    .insn_csr_wdata_i (insn_csr_wdata_i),
    .insn_csr_rdy_o   (insn_csr_rdy_o),
    .exc_vld_i        (exc_vld_i),
    .exc_code_i       (exc_code_i),
    .exc_pc_i         (exc_pc_i),
    .exc_tval_i       (exc_tval_i),
    .irq_i            (irq_i),
    .int_pc_i         (int_pc_i),
    .mret_i           (mret_i),
    .csr_o            (csr_o),
    .csr_addr_o       (csr_addr_o),
    .csr_vld_o        (csr_vld_o),
    .csr_i            (csr_i),
    .redirect_vld_o   (redirect_vld_o),
    .redirect_pc_o    (redirect_pc_o),
    .trap_busy_o      (trap_busy_o)
  );

  always #5 clk = ~clk;

  // CSR file stub: fixed read values chosen by the bench.
  logic [31:0] mtvec_v, mepc_v, other_v;
  always_comb begin
    if (csr_addr_o == A_MTVEC)     csr_i = mtvec_v;
    else if (csr_addr_o == A_MEPC) csr_i = mepc_v;
    else                           csr_i = other_v;
  end

  // One expected cycle of DUT output; fol=1 means csr_addr_o must echo insn_csr_addr_i.
  typedef struct packed {
    logic        busy;
    logic        rdy;
    logic        vld;
    logic        fol;
    logic [11:0] addr;
    logic [31:0] data;
    logic        rvld;
    logic [31:0] rpc;
  } exp_t;

  exp_t script[$];
  logic m_irq_en, m_s1, m_s2;
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic exp_t mk(input logic b, input logic r, input logic v, input logic f,
                              input logic [11:0] a, input logic [31:0] d,
                              input logic rv, input logic [31:0] rp);
    exp_t e;
    e.busy = b; e.rdy = r; e.vld = v; e.fol = f;
    e.addr = a; e.data = d; e.rvld = rv; e.rpc = rp;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Trap entry: three CSR saves, a vector read, then the redirect.
  task automatic push_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval);
    logic [31:0] tgt;
    tgt = mtvec_v & 32'hFFFF_FFFC;
    script.push_back(mk(1, 0, 1, 0, A_MEPC,   pc,    0, 0));
    script.push_back(mk(1, 0, 1, 0, A_MCAUSE, cause, 0, 0));
    script.push_back(mk(1, 0, 1, 0, A_MTVAL,  tval,  0, 0));
    script.push_back(mk(1, 0, 0, 0, A_MTVEC,  0,     0, 0));
    script.push_back(mk(1, 0, 0, 1, 12'h0,    0,     1, tgt));
    $display("txn trap pc=%h cause=%h tval=%h target=%h", pc, cause, tval, tgt);
  endtask

  // One clock cycle: predict, compare at the falling edge, then advance.
  task automatic cyc();
    exp_t e;
    logic take_irq;
    @(negedge clk);
    if (!rst) begin
      e = mk(0, 0, 0, 1, 12'h0, 0, 0, 0);
      script.delete();
      m_irq_en = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      if (script.size() > 0) begin
        e = script.pop_front();
      end else begin
        take_irq = m_s2 & m_irq_en;
        if (exc_vld_i) begin
          e = mk(1, 0, 0, 1, 12'h0, 0, 0, 0);
          m_irq_en = 1'b0;
          push_trap(exc_pc_i, {27'b0, exc_code_i}, exc_tval_i);
        end else if (take_irq) begin
          e = mk(1, 0, 0, 1, 12'h0, 0, 0, 0);
          m_irq_en = 1'b0;
          push_trap(int_pc_i, 32'h8000_000B, 32'h0);
        end else if (mret_i) begin
          e = mk(1, 0, 0, 1, 12'h0, 0, 0, 0);
          m_irq_en = 1'b1;
          script.push_back(mk(1, 0, 0, 0, A_MEPC, 0, 0, 0));
          script.push_back(mk(1, 0, 0, 1, 12'h0, 0, 1, mepc_v));
          $display("txn mret target=%h", mepc_v);
        end else begin
          e = mk(0, 1, insn_csr_vld_i, 1, 12'h0, insn_csr_vld_i ? insn_csr_wdata_i : 32'h0, 0, 0);
          if (insn_csr_vld_i) begin
            $display("txn csr_write addr=%h data=%h", insn_csr_addr_i, insn_csr_wdata_i);
            if (insn_csr_addr_i == A_MSTATUS) m_irq_en = insn_csr_wdata_i[3];
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = irq_i;
    end
    chk("trap_busy",    {31'b0, trap_busy_o},    {31'b0, e.busy});
    chk("insn_csr_rdy", {31'b0, insn_csr_rdy_o}, {31'b0, e.rdy});
    chk("csr_vld",      {31'b0, csr_vld_o},      {31'b0, e.vld});
    chk("csr_addr",     {20'b0, csr_addr_o},     {20'b0, e.fol ? insn_csr_addr_i : e.addr});
    chk("csr_data",     csr_o,                   e.data);
    chk("redirect_vld", {31'b0, redirect_vld_o}, {31'b0, e.rvld});
    chk("redirect_pc",  redirect_pc_o,           e.rpc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    insn_csr_vld_i = 0; insn_csr_addr_i = 12'h123; insn_csr_wdata_i = 0;
    exc_vld_i = 0; exc_code_i = 0; exc_pc_i = 0; exc_tval_i = 0;
    irq_i = 0; int_pc_i = 0; mret_i = 0;
    mtvec_v = 32'h803; mepc_v = 32'h204; other_v = 32'h1111_2222;
    m_irq_en = 0; m_s1 = 0; m_s2 = 0;

    // Reset state, then release.
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    // Exception: code 2, pc 0x100, tval 0xDEAD, mtvec 0x803 -> target 0x800.
    exc_vld_i = 1; exc_code_i = 5'd2; exc_pc_i = 32'h100; exc_tval_i = 32'hDEAD;
    cyc();
    exc_vld_i = 0;
    repeat (6) cyc();

    // Enable interrupts, hold irq: one entry, no re-entry while disabled.
    insn_csr_vld_i = 1; insn_csr_addr_i = A_MSTATUS; insn_csr_wdata_i = 32'h8;
    cyc();
    insn_csr_vld_i = 0; insn_csr_addr_i = 12'h0AB;
    irq_i = 1; int_pc_i = 32'h204;
    repeat (14) cyc();

    // mret to 0x204 re-enables; the held irq then re-enters.
    mepc_v = 32'h204;
    mret_i = 1;
    cyc();
    mret_i = 0;
    repeat (10) cyc();
    irq_i = 0;
    repeat (6) cyc();

    // Exception and insn write together: exception wins, write granted afterwards.
    exc_vld_i = 1; exc_code_i = 5'd7; exc_pc_i = 32'h440; exc_tval_i = 32'h9;
    insn_csr_vld_i = 1; insn_csr_addr_i = A_MEPC; insn_csr_wdata_i = 32'h55;
    cyc();
    exc_vld_i = 0;
    repeat (6) cyc();
    insn_csr_vld_i = 0;

    // Exception and enabled interrupt in the same cycle.
    insn_csr_vld_i = 1; insn_csr_addr_i = A_MSTATUS; insn_csr_wdata_i = 32'h8;
    cyc();
    insn_csr_vld_i = 0;
    irq_i = 1;
    cyc(); cyc();
    exc_vld_i = 1; exc_code_i = 5'd11; exc_pc_i = 32'h600; exc_tval_i = 32'h77;
    cyc();
    exc_vld_i = 0;
    repeat (10) cyc();
    irq_i = 0;
    cyc(); cyc();

    // Reset during SAVE_CAUSE abandons the sequence.
    exc_vld_i = 1; exc_code_i = 5'd4; exc_pc_i = 32'h900; exc_tval_i = 32'h1234;
    cyc();
    exc_vld_i = 0;
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    repeat (8) cyc();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if (script.size() == 0 && $urandom_range(0, 3) == 0) begin
        mtvec_v = $urandom;
        mepc_v  = $urandom;
      end
      other_v          = $urandom;
      rst              = ($urandom_range(0, 199) != 0);
      exc_vld_i        = ($urandom_range(0, 9) == 0);
      exc_code_i       = 5'($urandom_range(0, 31));
      exc_pc_i         = $urandom;
      exc_tval_i       = $urandom;
      int_pc_i         = $urandom;
      if ($urandom_range(0, 15) == 0) irq_i = ~irq_i;
      mret_i           = ($urandom_range(0, 11) == 0);
      insn_csr_vld_i   = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       insn_csr_addr_i = A_MSTATUS;
        1:       insn_csr_addr_i = A_MTVEC;
        2:       insn_csr_addr_i = A_MEPC;
        default: insn_csr_addr_i = 12'($urandom);
      endcase
      insn_csr_wdata_i = $urandom;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/q100_exu_trap_ctrl.md
Q100_EXU_TRAP_CTRL -- requirements
Module: q100_exu_trap_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-003 SHALL have port: insn_csr_vld_i  in  1  instruction CSR write request.
REQ-004 SHALL have port: insn_csr_addr_i  in  LEN_CSR_ADDR  instruction CSR address (read or write).
REQ-005 SHALL have port: insn_csr_wdata_i  in  LEN_CSR  instruction CSR write data.
REQ-006 SHALL have port: insn_csr_rdy_o  out  1  instruction request granted this cycle.
REQ-007 SHALL have port: exc_vld_i  in  1  synchronous exception pulse.
REQ-008 SHALL have ports: exc_code_i  in  5  exception code; exc_pc_i  in  32  faulting PC; exc_tval_i  in  32  trap value.
REQ-009 SHALL have ports: irq_i  in  1  level interrupt, async; int_pc_i  in  32  next-PC for interrupt entry.
REQ-010 SHALL have port: mret_i  in  1  trap-return pulse.
REQ-011 SHALL have ports: csr_o  out  LEN_CSR  write data; csr_addr_o  out  LEN_CSR_ADDR  address; csr_vld_o  out  1  write strobe (drive the CSR file).
REQ-012 SHALL have port: csr_i  in  LEN_CSR  combinational read data for csr_addr_o.
REQ-013 SHALL have ports: redirect_vld_o  out  1  fetch redirect pulse; redirect_pc_o  out  32  target; trap_busy_o  out  1  pipeline stall.

Function
REQ-014 SHALL implement states IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, READ_VEC, MRET_RD, REDIRECT.
REQ-015 In IDLE, event priority SHALL be exc_vld_i > (irq_sync & irq_en) > mret_i > insn_csr_vld_i; only one serviced per cycle.
REQ-016 On exception in IDLE: capture pc=exc_pc_i, cause={27'b0,exc_code_i}, tval=exc_tval_i; go SAVE_EPC.
REQ-017 On interrupt in IDLE: capture pc=int_pc_i, cause=32'h8000_000B, tval=0; go SAVE_EPC.
REQ-018 SAVE_EPC/SAVE_CAUSE/SAVE_TVAL SHALL each drive csr_vld_o=1 for one cycle to CSR_MEPC/CSR_MCAUSE/CSR_MTVAL with captured value, then advance in order to READ_VEC.
REQ-019 READ_VEC SHALL drive csr_addr_o=CSR_MTVEC, csr_vld_o=0, capture target={csr_i[31:2],2'b00}; go REDIRECT.
REQ-020 On mret_i in IDLE: go MRET_RD; MRET_RD SHALL drive csr_addr_o=CSR_MEPC, csr_vld_o=0, capture target=csr_i; go REDIRECT.
REQ-021 REDIRECT SHALL assert redirect_vld_o=1 with redirect_pc_o=target for exactly one cycle, then IDLE.
REQ-022 Latency: exception/interrupt accept -> redirect_vld_o exactly 5 cycles later; mret accept -> 2 cycles later.
REQ-023 trap_busy_o SHALL be 1 in every non-IDLE state and in the IDLE cycle an exception/interrupt/mret is accepted.
REQ-024 insn_csr_rdy_o SHALL be 1 only in IDLE with no higher-priority event; when 1 and insn_csr_vld_i=1, csr_vld_o=1, csr_addr_o=insn_csr_addr_i, csr_o=insn_csr_wdata_i same cycle.
REQ-025 In IDLE with no granted write, csr_addr_o SHALL follow insn_csr_addr_i (read path), csr_vld_o=0, csr_o=0.
REQ-026 irq_en SHALL be set/cleared by a granted insn write to CSR_MSTATUS bit 3, cleared on trap entry, set on mret accept.
REQ-027 exc_vld_i, irq, mret_i while not IDLE SHALL be ignored (no capture, no state change); level irq_i re-evaluated on return to IDLE.
REQ-028 Exception and irq in same cycle: exception taken; interrupt taken after redirect only if still asserted and irq_en re-set.
REQ-029 irq_i SHALL pass a two-flop synchronizer before use (2-cycle added delay).

Reset
REQ-030 On rst=0, asynchronously: state=IDLE, irq_en=0, captured regs=0, synchronizer=0; all outputs 0 except csr_addr_o (follows insn_csr_addr_i).
REQ-031 Reset mid-sequence SHALL abandon the sequence; no further CSR writes or redirect issued.

Structure
REQ-032 State enum and cause constants (IRQ_EXT_CAUSE=32'h8000_000B) SHALL live in a shared package; CSR addresses (CSR_MSTATUS 12'h300, CSR_MTVEC 12'h305, CSR_MEPC 12'h341, CSR_MCAUSE 12'h342, CSR_MTVAL 12'h343) SHALL be defined in q100_config.svh.
REQ-033 The synchronizer SHALL be sub-module q100_exu_irq_sync; no other sub-modules.

Verification
REQ-034 exc_vld_i, code=2, pc=0x100, tval=0xDEAD, csr_i(MTVEC)=0x803 -> writes MEPC=0x100, MCAUSE=2, MTVAL=0xDEAD in cycles 1-3; redirect_pc_o=0x800 at cycle 5.
REQ-035 Write MSTATUS=0x8, hold irq_i=1, int_pc_i=0x204 -> MEPC=0x204, MCAUSE=0x8000000B, MTVAL=0; irq_en=0 afterwards; no re-entry until mret.
REQ-036 mret_i with csr_i(MEPC)=0x204 -> redirect_pc_o=0x204 two cycles later; irq_en=1.
REQ-037 exc_vld_i and insn_csr_vld_i same cycle -> insn_csr_rdy_o=0, exception sequence runs; insn write granted first IDLE cycle after redirect.
REQ-038 irq_i=1 and exc_vld_i same cycle, irq_en=1 -> exception cause written; no interrupt entry.
REQ-039 rst=0 during SAVE_CAUSE -> all outputs 0 immediately, no MTVAL write, no redirect after release.
